// File: rtl/reg_readout_seq.sv
// Readout sequencer: latches a 32-bit read-only register, shifts it out MSB
// first and wraps the serial data into a frame of start bit, register address,
// data and even parity.
//
// state | meaning
// IDLE  | waiting for a request; clears frame outputs
// HDR   | latch strobe (bitCnt 0), then emit start bit and address bits
// DATA  | shift strobe each cycle, forward shiftIn to frameOut
// PAR   | emit parity bit together with readDone
module reg_readout_seq #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              bclk,
  input  logic              rstb,
  input  logic              clkEn,
  input  logic              readReq,
  input  logic [ADDR_W-1:0] readAddr,
  output logic              readBusy,
  output logic              latchOut,
  output logic              shiftEn,
  input  logic              shiftIn,
  output logic              frameOut,
  output logic              frameValid,
  output logic              readDone
);

  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              par_q, par_d;
  logic              frame_out_d, frame_valid_d, read_done_d;

  // Strobes and busy flag decode straight from the registered state so they
  // drop the instant reset asserts; clkEn gating keeps the register quiet
  // while the sequencer is stalled.
  always_comb begin
    latchOut = clkEn && (state_q == HDR) && (cnt_q == '0);
    shiftEn  = clkEn && (state_q == DATA);
    readBusy = (state_q != IDLE) || frameValid;
  end

  // Next-state and datapath: the address is held in a shift register and
  // leaves from its MSB, which gives MSB-first order without a variable index.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    par_d         = par_q;
    frame_out_d   = frameOut;
    frame_valid_d = frameValid;
    read_done_d   = readDone;
    case (state_q)
      IDLE: begin
        frame_out_d   = 1'b0;
        frame_valid_d = 1'b0;
        read_done_d   = 1'b0;
        if (readReq && !readBusy) begin
          addr_d  = readAddr;
          par_d   = 1'b0;
          cnt_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        frame_valid_d = 1'b1;
        if (cnt_q == '0) begin
          frame_out_d = 1'b1;
        end else begin
          frame_out_d = addr_q[ADDR_W-1];
          par_d       = par_q ^ addr_q[ADDR_W-1];
          addr_d      = addr_q << 1;
        end
        if (cnt_q == CNT_W'(ADDR_W)) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        frame_out_d = shiftIn;
        par_d       = par_q ^ shiftIn;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = PAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAR: begin
        frame_out_d = par_q;
        read_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything holds while clkEn is low.
  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      par_q      <= 1'b0;
      frameOut   <= 1'b0;
      frameValid <= 1'b0;
      readDone   <= 1'b0;
    end else if (clkEn) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      par_q      <= par_d;
      frameOut   <= frame_out_d;
      frameValid <= frame_valid_d;
      readDone   <= read_done_d;
    end
  end

endmodule

// File: tb/tb_reg_readout_seq.sv
// Bench for reg_readout_seq: models the readout register, predicts each frame
// into a queue when a read is requested and compares bits as they appear.
module tb_reg_readout_seq;

  logic       bclk = 1'b0;
  logic       rstb = 1'b1;
  logic       clkEn = 1'b1;
  logic       readReq = 1'b0;
  logic [6:0] readAddr = '0;
  logic       readBusy, latchOut, shiftEn, shiftIn;
  logic       frameOut, frameValid, readDone;

  reg_readout_seq #(.ADDR_W(7), .DATA_W(32)) dut (
    .bclk(bclk), .rstb(rstb), .clkEn(clkEn), .readReq(readReq),
    .readAddr(readAddr), .readBusy(readBusy), .latchOut(latchOut),
    .shiftEn(shiftEn), .shiftIn(shiftIn), .frameOut(frameOut),
    .frameValid(frameValid), .readDone(readDone)
  );

  always #5 bclk = ~bclk;

  typedef struct packed {
    logic b;
    logic last;
  } fbit_t;

  fbit_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // readout register model: parallel load on latchOut, shift left on shiftEn
  logic [31:0] reg_data = '0;
  logic [31:0] sr = '0;
  assign shiftIn = sr[31];
  always @(posedge bclk) begin
    if (latchOut) sr <= reg_data;
    else if (shiftEn) sr <= {sr[30:0], 1'b0};
  end

  logic last_en = 1'b0;
  always @(posedge bclk) last_en <= clkEn;

  int n_latch = 0, n_shift = 0, n_fv = 0, n_done = 0, n_overlap = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // strobe/valid counters and frame-bit scoreboard
  always @(negedge bclk) begin
    if (rstb) begin
      if (latchOut) n_latch++;
      if (shiftEn) n_shift++;
      if (frameValid) n_fv++;
      if (readDone) n_done++;
      if (latchOut && shiftEn) n_overlap++;
      if (frameValid && last_en) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_bit", 64'(frameValid), 64'd0);
        end else begin
          fbit_t e;
          e = exp_q.pop_front();
          check_eq("frame_bit", 64'(frameOut), 64'(e.b));
          check_eq("read_done", 64'(readDone), 64'(e.last));
        end
      end
    end
  end

  task automatic push_frame(input logic [6:0] a, input logic [31:0] d);
    fbit_t e;
    e.last = 1'b0;
    e.b = 1'b1;
    exp_q.push_back(e);
    for (int i = 6; i >= 0; i--) begin e.b = a[i]; exp_q.push_back(e); end
    for (int i = 31; i >= 0; i--) begin e.b = d[i]; exp_q.push_back(e); end
    e.b = (^a) ^ (^d);
    e.last = 1'b1;
    exp_q.push_back(e);
  endtask

  // one-cycle request; returns just after the accepting edge
  task automatic do_read(input logic [6:0] a, input logic [31:0] d);
    reg_data = d;
    readAddr = a;
    push_frame(a, d);
    readReq = 1'b1;
    @(posedge bclk); #1;
    readReq = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    @(negedge bclk);
    while (!readDone && n < bound) begin
      @(negedge bclk);
      n++;
    end
    check_eq(tag, 64'(readDone), 64'd1);
  endtask

  int b_latch, b_shift, b_fv, b_done;
  task automatic snap();
    b_latch = n_latch; b_shift = n_shift; b_fv = n_fv; b_done = n_done;
  endtask

  logic held_fo;

  initial begin
    #2 rstb = 1'b0;
    #2;
    check_eq("rst_frameOut", 64'(frameOut), 64'd0);
    check_eq("rst_frameValid", 64'(frameValid), 64'd0);
    check_eq("rst_readDone", 64'(readDone), 64'd0);
    check_eq("rst_readBusy", 64'(readBusy), 64'd0);
    check_eq("rst_strobes", {62'd0, latchOut, shiftEn}, 64'd0);
    repeat (3) @(posedge bclk);
    #1 rstb = 1'b1;
    repeat (2) @(posedge bclk);
    #1;

    // 1: basic frame with full timeline counts
    snap();
    do_read(7'h2A, 32'hDEADBEEF);
    @(negedge bclk);
    check_eq("t1_latch_c1", 64'(latchOut), 64'd1);
    check_eq("t1_fv_c1", 64'(frameValid), 64'd0);
    check_eq("t1_busy_c1", 64'(readBusy), 64'd1);
    wait_done("t1_done", 100);
    check_eq("t1_busy_c42", 64'(readBusy), 64'd1);
    @(negedge bclk);
    check_eq("t1_busy_c43", 64'(readBusy), 64'd0);
    check_eq("t1_fv_c43", 64'(frameValid), 64'd0);
    check_eq("t1_latch_cnt", 64'(n_latch - b_latch), 64'd1);
    check_eq("t1_shift_cnt", 64'(n_shift - b_shift), 64'd32);
    check_eq("t1_fv_cnt", 64'(n_fv - b_fv), 64'd41);
    check_eq("t1_done_cnt", 64'(n_done - b_done), 64'd1);
    check_eq("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // 2: all-zero frame
    @(posedge bclk); #1;
    do_read(7'h00, 32'h0);
    wait_done("t2_done", 100);
    check_eq("t2_parity", 64'(frameOut), 64'd0);
    @(negedge bclk);
    check_eq("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // 3: request and address change while busy are ignored
    @(posedge bclk); #1;
    snap();
    do_read(7'h2A, 32'hDEADBEEF);
    repeat (14) @(posedge bclk);
    #1 readReq = 1'b1; readAddr = 7'h55;
    @(posedge bclk); #1 readReq = 1'b0;
    wait_done("t3_done", 100);
    repeat (20) @(negedge bclk);
    check_eq("t3_latch_cnt", 64'(n_latch - b_latch), 64'd1);
    check_eq("t3_fv_cnt", 64'(n_fv - b_fv), 64'd41);
    check_eq("t3_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("t3_idle", 64'(readBusy), 64'd0);

    // 4: five-cycle clkEn stall in DATA
    @(posedge bclk); #1;
    snap();
    do_read(7'h2A, 32'hDEADBEEF);
    repeat (15) @(posedge bclk);
    #1 clkEn = 1'b0;
    @(negedge bclk);
    held_fo = frameOut;
    check_eq("t4_stall_shift", 64'(shiftEn), 64'd0);
    repeat (4) begin
      @(negedge bclk);
      check_eq("t4_stall_strobes", {62'd0, latchOut, shiftEn}, 64'd0);
      check_eq("t4_stall_fv", 64'(frameValid), 64'd1);
      check_eq("t4_stall_fo", 64'(frameOut), 64'(held_fo));
    end
    @(posedge bclk); #1 clkEn = 1'b1;
    wait_done("t4_done", 100);
    @(negedge bclk);
    check_eq("t4_shift_cnt", 64'(n_shift - b_shift), 64'd32);
    check_eq("t4_fv_cnt", 64'(n_fv - b_fv), 64'd46);
    check_eq("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // 5: reset mid-frame, then a clean read
    @(posedge bclk); #1;
    snap();
    do_read(7'h2A, 32'hDEADBEEF);
    repeat (19) @(posedge bclk);
    #1 rstb = 1'b0;
    #2;
    check_eq("t5_rst_fv", 64'(frameValid), 64'd0);
    check_eq("t5_rst_busy", 64'(readBusy), 64'd0);
    check_eq("t5_rst_shift", 64'(shiftEn), 64'd0);
    check_eq("t5_rst_fo", 64'(frameOut), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge bclk);
    #1 rstb = 1'b1;
    check_eq("t5_no_done", 64'(n_done - b_done), 64'd0);
    @(posedge bclk); #1;
    do_read(7'h01, 32'h12345678);
    wait_done("t5_done", 100);
    check_eq("t5_parity", 64'(frameOut), 64'd0);
    @(negedge bclk);
    check_eq("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // 6: readReq held high gives back-to-back frames
    snap();
    reg_data = 32'hA5A5A5A5;
    readAddr = 7'h33;
    push_frame(7'h33, 32'hA5A5A5A5);
    push_frame(7'h33, 32'hA5A5A5A5);
    readReq = 1'b1;
    wait_done("t6_done1", 100);
    @(negedge bclk);
    check_eq("t6_gap_fv", 64'(frameValid), 64'd0);
    check_eq("t6_gap_busy", 64'(readBusy), 64'd0);
    @(negedge bclk);
    check_eq("t6_latch2", 64'(latchOut), 64'd1);
    readReq = 1'b0;
    wait_done("t6_done2", 100);
    repeat (50) @(negedge bclk);
    check_eq("t6_latch_cnt", 64'(n_latch - b_latch), 64'd2);
    check_eq("t6_q_empty", 64'(exp_q.size()), 64'd0);

    check_eq("strobe_overlap", 64'(n_overlap), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
